imem_fetch: RTL

Parametrised, registered instruction memory for the RISC-V pipeline's fetch stage. It accepts fetch requests (PC) through a valid/ready handshake and returns the 32-bit instruction one cycle later. Stalls hold the response without loss, a flush discards in-flight fetches, and misaligned or out-of-range PCs are flagged. An optional write port loads the program at run time.

---
 rtl/imem_fetch.sv | 76 +++++++
 1 files changed

// File: rtl/imem_fetch.sv
// Registered instruction memory for the fetch stage: one-cycle read behind a valid/ready handshake.
// Define IMEM_PROG_PORT_EN to add the run-time program write port (prog_we/prog_addr/prog_data).
module imem_fetch #(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 256,
  parameter              INIT_FILE = "",
  parameter logic [31:0] NOP       = 32'h00000013,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_pc,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_instr,
  output logic            rsp_fault,
  output logic [31:0]     fetch_cnt
`ifdef IMEM_PROG_PORT_EN
  ,
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [31:0]     prog_data
`endif
);

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          misaligned;
  logic          out_of_range;
  logic          fault;
  logic          accept;
  logic          rsp_done;

`ifdef IMEM_PROG_PORT_EN
  // Nonblocking write gives read-before-write against a same-cycle fetch.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end
`endif

  always_comb begin
    idx          = req_pc[AW+1:2];
    misaligned   = |req_pc[1:0];
    out_of_range = |(req_pc >> (AW + 2));
    fault        = misaligned || out_of_range;
    req_ready    = !flush && (!rsp_valid || rsp_ready);
    accept       = req_valid && req_ready;
    rsp_done     = rsp_valid && rsp_ready && !flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_instr <= NOP;
      rsp_fault <= 1'b0;
      fetch_cnt <= 32'd0;
    end else begin
      if (rsp_done) fetch_cnt <= fetch_cnt + 32'd1;

      if (flush) begin
        rsp_valid <= 1'b0;
      end else if (accept) begin
        rsp_valid <= 1'b1;
        rsp_instr <= fault ? NOP : mem[idx];
        rsp_fault <= fault;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
